mult_share_arbiter: RTL

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

---
 rtl/mult_share_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/mult_share_arbiter.sv
// Shared radix-2 Booth multiplier serving N requesters through a round-robin arbiter.
// One operation at a time: grant, Y add/shift iterations, then hold the result until it is accepted.
module mult_share_arbiter #(
  parameter int X = 8,
  parameter int Y = 8,
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req_valid,
  output logic [N-1:0]          req_ready,
  input  logic [N*X-1:0]        req_a,
  input  logic [N*Y-1:0]        req_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [X+Y-1:0]        out_prod,
  output logic [IW-1:0]         out_id,
  output logic                  busy
);

  localparam int PW = X + Y + 2;
  localparam int CW = $clog2(Y + 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t                 state;
  logic [IW-1:0]          ptr;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          id_reg;
  logic signed [X-1:0]    a_reg;
  logic signed [PW-1:0]   prod;

  logic [N-1:0]           grant;
  logic                   found;
  logic [IW-1:0]          grant_id;

  // Layout of p: {acc[X:0], multiplier[Y-1:0], guard}; one Booth add/sub followed by an arithmetic shift.
  function automatic logic signed [PW-1:0] booth_step(input logic signed [PW-1:0] p,
                                                      input logic signed [X-1:0]  a);
    logic signed [X:0]    acc;
    logic signed [X:0]    ax;
    logic signed [PW-1:0] q;
    ax  = {a[X-1], a};
    acc = p[PW-1:Y+1];
    case (p[1:0])
      2'b01:   acc = acc + ax;
      2'b10:   acc = acc - ax;
      default: acc = acc;
    endcase
    q = {acc, p[Y:0]};
    return q >>> 1;
  endfunction

  // Round-robin pick: first valid requester at or above ptr, wrapping modulo N.
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    found    = 1'b0;
    grant_id = '0;
    if (state == IDLE && !rst) begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(ptr) + k) % N;
        if (!found && req_valid[idx]) begin
          found       = 1'b1;
          grant[idx]  = 1'b1;
          grant_id    = IW'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= '0;
      id_reg <= '0;
      a_reg  <= '0;
      prod   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            a_reg  <= req_a[grant_id*X +: X];
            prod   <= {{(X+1){1'b0}}, req_b[grant_id*Y +: Y], 1'b0};
            id_reg <= grant_id;
            ptr    <= IW'((int'(grant_id) + 1) % N);
            cnt    <= '0;
            state  <= ITER;
          end
        end
        ITER: begin
          prod <= booth_step(prod, a_reg);
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(Y - 1)) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The guard bit is dropped; the low X+Y bits above it hold the exact product.
  assign req_ready = grant;
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign out_prod  = out_valid ? prod[X+Y:1] : '0;
  assign out_id    = out_valid ? id_reg : '0;

endmodule
